// File: rtl/hazard_control_if.sv
// Signal bundle between the hazard controller and the pipeline datapath.
// The controller takes the master side; the datapath/stage latches take the slave side.
interface hazard_control_if #(
   parameter int CNTW = 32
);

   // Hazard sources reported by the pipeline
   logic            ihit;
   logic            dhit;
   logic            mem_dREN;
   logic            mem_dWEN;
   logic            ex_dREN;
   logic [4:0]      ex_rt;
   logic [4:0]      id_rs;
   logic [4:0]      id_rt;
   logic            id_uses_rt;
   logic            br_taken;
   logic            wb_halt;

   // Sequencing commands back to the pipeline
   logic            pcen;
   logic            deen;
   logic            exen;
   logic            memen;
   logic            wben;
   logic            de_flush;
   logic            ex_flush;
   logic            iREN;
   logic            halt;
   logic [CNTW-1:0] stall_cnt;
   logic [CNTW-1:0] flush_cnt;

   modport master (
      input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_rt,
             id_rs, id_rt, id_uses_rt, br_taken, wb_halt,
      output pcen, deen, exen, memen, wben, de_flush, ex_flush,
             iREN, halt, stall_cnt, flush_cnt
   );

   modport slave (
      output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_rt,
             id_rs, id_rt, id_uses_rt, br_taken, wb_halt,
      input  pcen, deen, exen, memen, wben, de_flush, ex_flush,
             iREN, halt, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_control.sv
// Five-stage pipeline sequencing controller: PC/latch enables, bubble insertion,
// fetch gating, sticky halt, and saturating stall/flush performance counters.
module hazard_control #(
   parameter int CNTW = 32
) (
   input  logic             CLK,
   input  logic             RST,
   hazard_control_if.master hc
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DACC = 2'd1,
      HALT = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

   logic dmem;
   logic ld_use;
   logic pcen, deen, exen, memen, wben;
   logic de_flush, ex_flush, iren, halt;
   logic flush_evt;

   assign dmem   = hc.mem_dREN | hc.mem_dWEN;
   assign ld_use = hc.ex_dREN && (hc.ex_rt != 5'd0) &&
                   ((hc.ex_rt == hc.id_rs) || (hc.id_uses_rt && (hc.ex_rt == hc.id_rt)));

   // Priority: reset, halt, data wait, redirect, load-use, fetch miss, normal.
   // NOTE: every output gets a default before the priority chain so no path leaves one unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      pcen      = 1'b0;
      deen      = 1'b0;
      exen      = 1'b0;
      memen     = 1'b0;
      wben      = 1'b0;
      de_flush  = 1'b0;
      ex_flush  = 1'b0;
      iren      = 1'b0;
      halt      = 1'b0;
      flush_evt = 1'b0;

      if (RST) begin
         state_d = RUN;
      end else if (state_q == HALT) begin
         halt = 1'b1;
      end else if (dmem && !hc.dhit) begin
         state_d = DACC;
      end else begin
         state_d = hc.wb_halt ? HALT : RUN;
         iren    = 1'b1;
         exen    = 1'b1;
         memen   = 1'b1;
         wben    = 1'b1;
         if (hc.br_taken) begin
            // The wrong-path load (if any) is squashed, so redirect beats load-use
            pcen      = 1'b1;
            deen      = 1'b1;
            de_flush  = 1'b1;
            ex_flush  = 1'b1;
            flush_evt = 1'b1;
         end else if (ld_use) begin
            ex_flush = 1'b1;
         end else if (!hc.ihit) begin
            deen     = 1'b1;
            de_flush = 1'b1;
         end else begin
            pcen = 1'b1;
            deen = 1'b1;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!RST && (state_q != HALT) && !pcen && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNTW'(1);
      if (flush_evt && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNTW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hc.pcen      = pcen;
   assign hc.deen      = deen;
   assign hc.exen      = exen;
   assign hc.memen     = memen;
   assign hc.wben      = wben;
   assign hc.de_flush  = de_flush;
   assign hc.ex_flush  = ex_flush;
   assign hc.iREN      = iren;
   assign hc.halt      = halt;
   assign hc.stall_cnt = stall_cnt_q;
   assign hc.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: a 32-bit-counter instance and a 4-bit-counter
// instance share stimulus; outputs are compared against hand-derived vectors.
module tb_hazard_control;

   logic CLK;
   logic RST;

   hazard_control_if #(.CNTW(32)) bus ();
   hazard_control_if #(.CNTW(4))  bus4 ();

   hazard_control #(.CNTW(32)) dut  (.CLK(CLK), .RST(RST), .hc(bus.master));
   hazard_control #(.CNTW(4))  dut4 (.CLK(CLK), .RST(RST), .hc(bus4.master));

   assign bus4.ihit       = bus.ihit;
   assign bus4.dhit       = bus.dhit;
   assign bus4.mem_dREN   = bus.mem_dREN;
   assign bus4.mem_dWEN   = bus.mem_dWEN;
   assign bus4.ex_dREN    = bus.ex_dREN;
   assign bus4.ex_rt      = bus.ex_rt;
   assign bus4.id_rs      = bus.id_rs;
   assign bus4.id_rt      = bus.id_rt;
   assign bus4.id_uses_rt = bus.id_uses_rt;
   assign bus4.br_taken   = bus.br_taken;
   assign bus4.wb_halt    = bus.wb_halt;

   // {pcen, deen, exen, memen, wben, de_flush, ex_flush, iREN, halt}
   localparam logic [8:0] V_OFF   = 9'b00000_00_0_0;
   localparam logic [8:0] V_NORM  = 9'b11111_00_1_0;
   localparam logic [8:0] V_LDU   = 9'b00111_01_1_0;
   localparam logic [8:0] V_MISS  = 9'b01111_10_1_0;
   localparam logic [8:0] V_BR    = 9'b11111_11_1_0;
   localparam logic [8:0] V_HALT  = 9'b00000_00_0_1;

   int n_cmp = 0;
   int n_bad = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   function automatic logic [8:0] outs();
      return {bus.pcen, bus.deen, bus.exen, bus.memen, bus.wben,
              bus.de_flush, bus.ex_flush, bus.iREN, bus.halt};
   endfunction

   function automatic logic [8:0] outs4();
      return {bus4.pcen, bus4.deen, bus4.exen, bus4.memen, bus4.wben,
              bus4.de_flush, bus4.ex_flush, bus4.iREN, bus4.halt};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus.ihit       = 1'b1;
      bus.dhit       = 1'b0;
      bus.mem_dREN   = 1'b0;
      bus.mem_dWEN   = 1'b0;
      bus.ex_dREN    = 1'b0;
      bus.ex_rt      = 5'd0;
      bus.id_rs      = 5'd0;
      bus.id_rt      = 5'd0;
      bus.id_uses_rt = 1'b0;
      bus.br_taken   = 1'b0;
      bus.wb_halt    = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      clear_inputs();
      settle();
      check("reset_outs", 32'(outs()), 32'(V_OFF));
      check("reset_stall", bus.stall_cnt, 32'd0);
      check("reset_flush", bus.flush_cnt, 32'd0);
      tick();
      tick();
      RST = 1'b0;

      // Normal flow, no hazards
      for (int i = 0; i < 10; i++) begin
         settle();
         check("normal_outs", 32'(outs()), 32'(V_NORM));
         tick();
      end
      check("normal_stall", bus.stall_cnt, 32'd0);
      check("normal_flush", bus.flush_cnt, 32'd0);

      // Load-use on rs
      bus.ex_dREN = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
      settle();
      check("lduse_rs_outs", 32'(outs()), 32'(V_LDU));
      tick();
      check("lduse_rs_stall", bus.stall_cnt, 32'd1);
      bus.ex_dREN = 1'b0;
      settle();
      check("lduse_bubble_outs", 32'(outs()), 32'(V_NORM));
      tick();
      check("lduse_once_stall", bus.stall_cnt, 32'd1);

      // Register zero never creates a hazard
      bus.ex_dREN = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
      settle();
      check("lduse_r0_outs", 32'(outs()), 32'(V_NORM));
      tick();
      check("lduse_r0_stall", bus.stall_cnt, 32'd1);

      // rt match only counts when the instruction reads rt
      bus.ex_rt = 5'd7; bus.id_rs = 5'd3; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b0;
      settle();
      check("lduse_rt_unused_outs", 32'(outs()), 32'(V_NORM));
      tick();
      bus.id_uses_rt = 1'b1;
      settle();
      check("lduse_rt_outs", 32'(outs()), 32'(V_LDU));
      tick();
      check("lduse_rt_stall", bus.stall_cnt, 32'd2);
      clear_inputs();

      // Data-memory wait for 3 cycles; branch during DACC is held off
      bus.mem_dREN = 1'b1; bus.dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) bus.br_taken = 1'b1;
         settle();
         check("dwait_outs", 32'(outs()), 32'(V_OFF));
         tick();
      end
      check("dwait_stall", bus.stall_cnt, 32'd5);
      bus.dhit = 1'b1; bus.br_taken = 1'b0;
      settle();
      check("dwait_release_outs", 32'(outs()), 32'(V_NORM));
      tick();
      check("dwait_release_stall", bus.stall_cnt, 32'd5);
      check("dwait_release_flush", bus.flush_cnt, 32'd0);
      clear_inputs();

      // Branch held during DACC is applied in the dhit cycle
      bus.mem_dWEN = 1'b1; bus.dhit = 1'b0; bus.br_taken = 1'b1;
      settle();
      check("dacc_br_wait_outs", 32'(outs()), 32'(V_OFF));
      tick();
      bus.dhit = 1'b1;
      settle();
      check("dacc_br_apply_outs", 32'(outs()), 32'(V_BR));
      tick();
      check("dacc_br_flush", bus.flush_cnt, 32'd1);
      check("dacc_br_stall", bus.stall_cnt, 32'd6);
      clear_inputs();

      // Access completing in the same RUN cycle causes no stall
      bus.mem_dREN = 1'b1; bus.dhit = 1'b1;
      settle();
      check("dhit_same_cycle_outs", 32'(outs()), 32'(V_NORM));
      tick();
      check("dhit_same_cycle_stall", bus.stall_cnt, 32'd6);
      clear_inputs();

      // Branch beats load-use and fetch miss
      bus.br_taken = 1'b1; bus.ex_dREN = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
      bus.ihit = 1'b0;
      settle();
      check("br_over_lduse_outs", 32'(outs()), 32'(V_BR));
      tick();
      check("br_over_lduse_flush", bus.flush_cnt, 32'd2);
      check("br_over_lduse_stall", bus.stall_cnt, 32'd6);
      bus.br_taken = 1'b0; bus.ex_dREN = 1'b0;
      settle();
      check("imiss_outs", 32'(outs()), 32'(V_MISS));
      tick();
      check("imiss_stall", bus.stall_cnt, 32'd7);
      check("cnt4_stall_mid", 32'(bus4.stall_cnt), 32'd7);
      check("cnt4_flush_mid", 32'(bus4.flush_cnt), 32'd2);
      clear_inputs();

      // Halt waits for the pending store
      bus.wb_halt = 1'b1; bus.mem_dWEN = 1'b1; bus.dhit = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("halt_pending_outs", 32'(outs()), 32'(V_OFF));
         tick();
      end
      bus.dhit = 1'b1;
      settle();
      check("halt_dhit_outs", 32'(outs()), 32'(V_NORM));
      tick();
      clear_inputs();
      settle();
      check("halted_outs", 32'(outs()), 32'(V_HALT));
      tick();
      bus.mem_dREN = 1'b1; bus.br_taken = 1'b1;
      settle();
      check("halted_sticky_outs", 32'(outs()), 32'(V_HALT));
      tick();
      clear_inputs();
      settle();
      check("halted_sticky2_outs", 32'(outs()), 32'(V_HALT));
      check("halted_stall", bus.stall_cnt, 32'd9);
      check("halted_flush", bus.flush_cnt, 32'd2);

      // Reset pulse leaves HALT
      RST = 1'b1;
      settle();
      check("rst_pulse_outs", 32'(outs()), 32'(V_OFF));
      check("rst_pulse_stall", bus.stall_cnt, 32'd0);
      check("rst_pulse_flush", bus.flush_cnt, 32'd0);
      tick();
      RST = 1'b0;
      settle();
      check("post_rst_outs", 32'(outs()), 32'(V_NORM));
      tick();

      // Fetch misses drive the narrow counter into saturation
      bus.ihit = 1'b0;
      for (int i = 0; i < 14; i++) begin
         settle();
         check("sat_miss_outs", 32'(outs4()), 32'(V_MISS));
         tick();
      end
      check("sat_cnt4_14", 32'(bus4.stall_cnt), 32'd14);
      tick();
      check("sat_cnt4_15", 32'(bus4.stall_cnt), 32'd15);
      for (int i = 0; i < 5; i++) tick();
      check("sat_cnt4_hold", 32'(bus4.stall_cnt), 32'd15);
      check("sat_cnt32_20", bus.stall_cnt, 32'd20);
      check("sat_cnt4_flush", 32'(bus4.flush_cnt), 32'd0);
      bus.ihit = 1'b1;
      settle();
      check("final_outs", 32'(outs()), 32'(V_NORM));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline sequencing controller for the five-stage core. It produces PC enable, per-latch enables and flushes for IF/ID, ID/EX, EX/MEM and MEM/WB, and gates instruction fetch on the shared memory port. It resolves the following, in priority order: data-memory wait, taken branch/jump redirect, load-use hazard, instruction-fetch miss and halt. It also keeps two saturating performance counters. It sits beside the stage latches, and its deen/de_flush drive the decode latch's enable and flush inputs directly.

## Interface
- CNTW, 32, width of performance counters
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_dREN, mem_dWEN  in  1 each  instruction in EX/MEM latch reads/writes memory
- ex_dREN  in  1  instruction in ID/EX latch is a load
- ex_rt  in  5  destination register of that load
- id_rs, id_rt  in  5  source registers of instruction in IF/ID latch
- id_uses_rt  in  1  IF/ID instruction reads rt
- br_taken  in  1  branch/jump in EX/MEM latch resolved taken
- wb_halt  in  1  halt opcode present in MEM/WB latch
- pcen, deen, exen, memen, wben  out  1 each  PC / latch load enables
- de_flush, ex_flush  out  1 each  load bubble into IF/ID / ID/EX (flush overrides enable)
- iREN  out  1  instruction read request
- halt  out  1  core halted, sticky
- stall_cnt, flush_cnt  out  CNTW each  performance counters

## Operation
- State register: RUN, DACC, HALT. All outputs except counters are combinational from state and inputs.
- dmem = mem_dREN | mem_dWEN.
- ld_use = ex_dREN & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Output rules, first match wins:
  1. HALT: all enables 0, flushes 0, iREN 0, halt 1.
  2. dmem & !dhit (RUN or DACC): all enables 0, flushes 0, iREN 0. Next state is DACC.
  3. br_taken: pcen=deen=exen=memen=wben=1, de_flush=ex_flush=1, iREN 1. The wrong-path load is squashed, so this rule overrides ld_use, and it ignores ihit.
  4. ld_use: pcen=0, deen=0 (hold IF/ID), ex_flush=1, exen=memen=wben=1, de_flush=0.
  5. !ihit: pcen=0, de_flush=1, exen=memen=wben=1, deen=1, ex_flush=0.
  6. Normal: all enables 1, flushes 0, iREN 1.
- In rules 3–6, iREN=1 and halt=0.
- Transitions:
  - RUN→DACC on rule 2.
  - DACC→RUN on dhit, with the rule 3–6 outputs applied that same cycle.
  - Any state→HALT when wb_halt=1 and rule 2 is not active.
  - HALT is left only by RST.
- stall_cnt increments every cycle in RUN/DACC with pcen=0.
- flush_cnt increments every cycle rule 3 is applied.
- Both counters saturate at 2^CNTW−1 and never wrap.

## Timing
- RST asserted: state=RUN, counters 0, halt 0.
  - While RST is high, all enables, flushes and iREN are forced to 0 regardless of state.
  - Deassertion takes effect on the next CLK edge; RST mid-stall or in HALT returns to RUN with no residual DACC.
- Decision latency 0: enables and flushes are valid in the same cycle as the inputs and are consumed at the next edge.
- Counter outputs are registered and reflect events up to the previous edge.
- dmem & dhit in the same RUN cycle: no stall, no DACC entry.
- A load-use stall lasts exactly 1 cycle. Next cycle the load is in EX/MEM, so ex_dREN is from the bubble (0).
- wb_halt while a data access is pending: HALT entry waits until dhit.
- br_taken during DACC has no effect until dhit; it is then applied in the dhit cycle.

## Test plan
- Reset then ihit=1, no hazards:
  - All enables 1, flushes 0, iREN 1.
  - Counters stay 0 for 10 cycles.
- ex_dREN=1, ex_rt=5, id_rs=5, ihit=1:
  - pcen=0, deen=0, ex_flush=1 for exactly one cycle.
  - stall_cnt=1 after the edge.
  - Repeat with ex_rt=0: no stall.
- mem_dREN=1, dhit=0 for 3 cycles, then dhit=1:
  - 3 cycles with all enables 0 and iREN 0, state DACC.
  - Normal outputs in the dhit cycle; stall_cnt=3.
- br_taken=1 together with ld_use=1 and ihit=0:
  - pcen=1, de_flush=1, ex_flush=1, no load-use stall.
  - flush_cnt increments by 1.
- wb_halt=1 with mem_dWEN=1, dhit=0 for 2 cycles:
  - Halt=0 until dhit; then halt=1 and all enables 0 permanently.
  - RST pulse returns outputs to normal run.
- Force CNTW=4 and hold ihit=0 for 20 cycles:
  - stall_cnt saturates at 15.
